// File: rtl/sent_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sent_pkg
//  Description : Shared constants, pulse-kind and FSM state encodings, and the
//                pulse-length helper for the SENT transmit pulse generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package sent_pkg;

    localparam int unsigned SYNC_TICKS        = 56;
    localparam int unsigned NIBBLE_BASE_TICKS = 12;
    localparam int unsigned PAUSE_MIN_TICKS   = 12;
    localparam int unsigned PAUSE_MAX_TICKS   = 768;

    typedef enum logic [1:0] {
        KIND_SYNC  = 2'd0,
        KIND_PAUSE = 2'd1,
        KIND_DATA  = 2'd2
    } pulse_kind_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    // Total pulse length in ticks, LOW phase included; pause is clamped.
    function automatic int unsigned calc_len(pulse_kind_t kind, logic [3:0] nibble,
                                             int unsigned pause_ticks);
        int unsigned len;
        case (kind)
            KIND_SYNC:  len = SYNC_TICKS;
            KIND_PAUSE: begin
                if (pause_ticks < PAUSE_MIN_TICKS)      len = PAUSE_MIN_TICKS;
                else if (pause_ticks > PAUSE_MAX_TICKS) len = PAUSE_MAX_TICKS;
                else                                    len = pause_ticks;
            end
            default:    len = NIBBLE_BASE_TICKS + 32'(nibble);
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sent_tx_pulse_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : sent_tx_pulse_gen_if
//  Description : Request/status bundle between the SENT transmit controller
//                (master) and the pulse generator (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sent_tx_pulse_gen_if #(
    parameter int TW = 10
);
    logic          sync;
    logic          pulse;
    logic          pause;
    logic [3:0]    data_nibble;
    logic [TW-1:0] pause_ticks;
    logic          sent_out;
    logic          pulse_done;
    logic          busy;
    logic          proto_err;

    modport master (
        output sync, pulse, pause, data_nibble, pause_ticks,
        input  sent_out, pulse_done, busy, proto_err
    );

    modport slave (
        input  sync, pulse, pause, data_nibble, pause_ticks,
        output sent_out, pulse_done, busy, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/sent_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sent_tick_gen
//  Description : Tick prescaler; counts 0..CLK_PER_TICK-1 and flags the
//                terminal count. i_clr holds it at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module sent_tick_gen #(
    parameter int CLK_PER_TICK = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_tick
);

    logic [7:0] r_cnt;
    logic       w_term;

    assign w_term = (r_cnt == 8'(CLK_PER_TICK - 1));
    assign o_tick = w_term;

    // Prescale counter: wraps on terminal count, forced to zero by clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= 8'd0;
        else if (i_clr || w_term)
            r_cnt <= 8'd0;
        else
            r_cnt <= r_cnt + 8'd1;
    end

endmodule
`default_nettype wire

// File: rtl/sent_tx_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sent_tx_pulse_gen
//  Description : Converts sync / data / pause level requests into tick-timed
//                SENT line pulses (fixed low phase, then high phase).
//  Revision    : 1.0 - initial release
// ============================================================================
module sent_tx_pulse_gen
    import sent_pkg::*;
#(
    parameter int CLK_PER_TICK = 3,
    parameter int LOW_TICKS    = 5,
    parameter int TW           = 10
) (
    input  logic              clk,
    input  logic              reset,
    sent_tx_pulse_gen_if.slave bus
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tick_cnt;
    logic [TW-1:0] r_len;
    logic [TW-1:0] w_len;
    pulse_kind_t   w_kind;
    logic          w_tick;
    logic          w_clr;
    logic          w_any;
    logic          w_low_last;
    logic          w_high_last;
    logic          w_latch;
    logic          w_pulse_end;

    // Prescaler restarts with every pulse launched from IDLE.
    assign w_clr = (r_state == IDLE);

    sent_tick_gen #(
        .CLK_PER_TICK(CLK_PER_TICK)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    assign w_any       = bus.sync | bus.pulse | bus.pause;
    assign w_low_last  = (r_state == LOW)  && w_tick && (r_tick_cnt == TW'(LOW_TICKS - 1));
    assign w_high_last = (r_state == HIGH) && w_tick && (r_tick_cnt == r_len - TW'(1));
    assign w_pulse_end = w_high_last | (w_low_last & ~w_any);
    assign w_len       = TW'(calc_len(w_kind, bus.data_nibble, 32'(bus.pause_ticks)));

    // Request priority at the latch point: sync > pause > data.
    always_comb begin
        w_kind = KIND_DATA;
        if (bus.sync)
            w_kind = KIND_SYNC;
        else if (bus.pause)
            w_kind = KIND_PAUSE;
    end

    // FSM state register; async reset forces the line high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and line/status outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_latch        = 1'b0;
        bus.sent_out   = 1'b1;
        bus.busy       = 1'b0;
        bus.pulse_done = 1'b0;
        bus.proto_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any)
                    w_state_nxt = LOW;
            end
            LOW: begin
                bus.sent_out = 1'b0;
                bus.busy     = 1'b1;
                if (w_low_last) begin
                    if (w_any) begin
                        w_latch     = 1'b1;
                        w_state_nxt = HIGH;
                    end else begin
                        bus.proto_err = 1'b1;
                        w_state_nxt   = IDLE;
                    end
                end
            end
            HIGH: begin
                bus.busy = 1'b1;
                if (w_high_last) begin
                    bus.pulse_done = 1'b1;
                    w_state_nxt    = w_any ? LOW : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // In-pulse tick counter (LOW ticks included) and latched pulse length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_len      <= '0;
        end else begin
            if (r_state == IDLE || w_pulse_end)
                r_tick_cnt <= '0;
            else if (w_tick)
                r_tick_cnt <= r_tick_cnt + TW'(1);
            if (w_latch)
                r_len <= w_len;
        end
    end

endmodule
`default_nettype wire
